result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer.sv | 132 +++++++++++++
 tb/tb_result_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// ============================================================================
//  Module      : result_serializer
//  Description : Frames 32-bit ALU results as HEADER + 4 data bytes + XOR
//                checksum for a byte-wide UART transmitter. One pending slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_serializer #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        alu_done,
    input  logic [31:0] result,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_active;
    logic [31:0] r_pend;
    logic        r_pend_vld;
    logic [2:0]  r_idx;
    logic [7:0]  r_tx_data;
    logic        r_ovf;

    logic        w_last;
    logic        w_adv;
    logic        w_start_idle;
    logic        w_reload;
    logic [31:0] w_frame_src;

    function automatic logic [7:0] frame_byte(input logic [31:0] d, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = HEADER;
            3'd1:    b = d[31:24];
            3'd2:    b = d[23:16];
            3'd3:    b = d[15:8];
            3'd4:    b = d[7:0];
            3'd5:    b = d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        w_last       = (r_state == WAIT) && tx_done && (r_idx == 3'd5);
        w_adv        = (r_state == WAIT) && tx_done && (r_idx != 3'd5);
        w_start_idle = (r_state == IDLE) && alu_done;
        // A pending result takes priority over a result arriving on the last tx_done
        w_reload     = w_last && (r_pend_vld || alu_done);
        w_frame_src  = (w_last && r_pend_vld) ? r_pend : result;
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (alu_done) w_next = SEND;
            SEND:    w_next = WAIT;
            WAIT: begin
                if (w_adv || w_reload) begin
                    w_next = SEND;
                end else if (w_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_active   <= 32'h0;
            r_pend     <= 32'h0;
            r_pend_vld <= 1'b0;
            r_idx      <= 3'd0;
            r_tx_data  <= 8'h00;
            r_ovf      <= 1'b0;
        end else begin
            if (w_start_idle || w_reload) begin
                r_active  <= w_frame_src;
                r_idx     <= 3'd0;
                r_tx_data <= HEADER;
            end else if (w_adv) begin
                r_idx     <= r_idx + 3'd1;
                r_tx_data <= frame_byte(r_active, r_idx + 3'd1);
            end

            if (w_last && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            // Busy capture: fill the empty slot, otherwise drop and flag
            if (alu_done && (r_state != IDLE)) begin
                if (r_pend_vld) begin
                    r_ovf <= 1'b1;
                end else if (!w_last) begin
                    r_pend     <= result;
                    r_pend_vld <= 1'b1;
                end
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = (r_state == SEND);
    assign busy     = (r_state != IDLE);
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_result_serializer.sv
// ============================================================================
//  Module      : tb_result_serializer
//  Description : Directed, self-checking bench for result_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_serializer;

    logic        clk;
    logic        n_rst;
    logic        alu_done;
    logic [31:0] result;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    logic m_pend = 1'b0;
    logic m_ovf  = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic [47:0] exp;
        int          gap;
    } vec_t;

    vec_t vecs [6];

    result_serializer #(.HEADER(8'hA5)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .alu_done (alu_done),
        .result   (result),
        .tx_done  (tx_done),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start(input logic [31:0] val);
        result   = val;
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
    endtask

    // Expects byte 0 already presented; answers each byte gap cycles later.
    task automatic frame(input logic [47:0] exp, input int gap, input logic [5:0] inj_mask,
                         input logic [31:0] inj_base, input logic sim, input logic [31:0] sim_val);
        int   k;
        logic nxt;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("valid_b%0d", i), {47'h0, tx_valid}, 48'h1);
            chk($sformatf("data_b%0d", i), {40'h0, tx_data}, {40'h0, exp[47-8*i -: 8]});
            chk($sformatf("busy_b%0d", i), {47'h0, busy}, 48'h1);
            step();
            chk($sformatf("single_pulse_b%0d", i), {47'h0, tx_valid}, 48'h0);
            if (inj_mask[i]) begin
                result   = inj_base + k;
                k++;
                alu_done = 1'b1;
            end
            step();
            alu_done = 1'b0;
            if (inj_mask[i]) begin
                if (m_pend) m_ovf = 1'b1;
                else        m_pend = 1'b1;
            end
            chk($sformatf("ovf_b%0d", i), {47'h0, overflow}, {47'h0, m_ovf});
            repeat (gap - 2) step();
            chk($sformatf("hold_b%0d", i), {40'h0, tx_data}, {40'h0, exp[47-8*i -: 8]});
            tx_done = 1'b1;
            if (i == 5 && sim) begin
                result   = sim_val;
                alu_done = 1'b1;
            end
            step();
            tx_done  = 1'b0;
            alu_done = 1'b0;
        end
        nxt = m_pend | sim;
        if (sim && m_pend) m_ovf = 1'b1;
        m_pend = 1'b0;
        chk("next_hdr_valid", {47'h0, tx_valid}, {47'h0, nxt});
        chk("end_busy", {47'h0, busy}, {47'h0, nxt});
        chk("end_ovf", {47'h0, overflow}, {47'h0, m_ovf});
    endtask

    initial begin
        vecs[0] = '{32'h12345678, 48'hA5_12345678_08, 10};
        vecs[1] = '{32'hDEADBEEF, 48'hA5_DEADBEEF_22, 2};
        vecs[2] = '{32'hA5A5A5A5, 48'hA5_A5A5A5A5_00, 3};
        vecs[3] = '{32'h01020304, 48'hA5_01020304_04, 4};
        vecs[4] = '{32'h80000001, 48'hA5_80000001_81, 5};
        vecs[5] = '{32'hFFFFFFFF, 48'hA5_FFFFFFFF_00, 7};

        n_rst = 1'b1; alu_done = 1'b0; tx_done = 1'b0; result = 32'h0;
        repeat (2) step();
        chk("rst_data", {40'h0, tx_data}, 48'h0);
        chk("rst_valid", {47'h0, tx_valid}, 48'h0);
        chk("rst_busy", {47'h0, busy}, 48'h0);
        chk("rst_ovf", {47'h0, overflow}, 48'h0);
        n_rst = 1'b0;
        step();
        chk("post_rst_valid", {47'h0, tx_valid}, 48'h0);

        // Spurious tx_done in IDLE
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("idle_txdone_valid", {47'h0, tx_valid}, 48'h0);
        chk("idle_txdone_busy", {47'h0, busy}, 48'h0);
        step();
        chk("idle_txdone_valid2", {47'h0, tx_valid}, 48'h0);

        // Table of single frames with varying transmitter latency
        for (int v = 0; v < 6; v++) begin
            start(vecs[v].res);
            frame(vecs[v].exp, vecs[v].gap, 6'b0, 32'h0, 1'b0, 32'h0);
            step();
            chk("idle_gap_valid", {47'h0, tx_valid}, 48'h0);
        end

        // Back-to-back: second result arrives during byte 2
        start(32'h12345678);
        frame(48'hA5_12345678_08, 4, 6'b000100, 32'hFFFF0000, 1'b0, 32'h0);
        frame(48'hA5_FFFF0000_00, 3, 6'b0, 32'h0, 1'b0, 32'h0);
        chk("b2b_ovf", {47'h0, overflow}, 48'h0);

        // Simultaneous alu_done with last tx_done, pending empty
        start(32'h11223344);
        frame(48'hA5_11223344_44, 3, 6'b0, 32'h0, 1'b1, 32'h000000FF);
        frame(48'hA5_000000FF_FF, 3, 6'b0, 32'h0, 1'b0, 32'h0);

        // Overflow: 1 active, 2 pending, 3 dropped
        start(32'h1);
        frame(48'hA5_00000001_01, 4, 6'b000110, 32'h2, 1'b0, 32'h0);
        frame(48'hA5_00000002_02, 3, 6'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("ovf_sticky", {47'h0, overflow}, 48'h1);
        chk("ovf_idle_valid", {47'h0, tx_valid}, 48'h0);

        // Reset mid-frame with pending full; tx_done during SEND ignored
        start(32'h12345678);
        chk("rm_hdr", {40'h0, tx_data}, 48'hA5);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("send_txdone_valid", {47'h0, tx_valid}, 48'h0);
        chk("send_txdone_data", {40'h0, tx_data}, 48'hA5);
        result = 32'h1; alu_done = 1'b1;
        step();
        result = 32'h2;
        step();
        alu_done = 1'b0;
        chk("rm_ovf_set", {47'h0, overflow}, 48'h1);
        for (int b = 1; b <= 3; b++) begin
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            chk($sformatf("rm_valid_b%0d", b), {47'h0, tx_valid}, 48'h1);
            chk($sformatf("rm_data_b%0d", b), {40'h0, tx_data},
                (b == 1) ? 48'h12 : (b == 2) ? 48'h34 : 48'h56);
            if (b < 3) step();
        end
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        m_pend = 1'b0; m_ovf = 1'b0;
        chk("rm_busy", {47'h0, busy}, 48'h0);
        chk("rm_valid", {47'h0, tx_valid}, 48'h0);
        chk("rm_ovf", {47'h0, overflow}, 48'h0);
        chk("rm_data", {40'h0, tx_data}, 48'h0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rm_stray_valid", {47'h0, tx_valid}, 48'h0);
            chk("rm_stray_busy", {47'h0, busy}, 48'h0);
            step();
        end

        // Simultaneous alu_done with last tx_done, pending full: dropped
        start(32'hA);
        frame(48'hA5_0000000A_0A, 3, 6'b000010, 32'hB, 1'b1, 32'hC);
        frame(48'hA5_0000000B_0B, 3, 6'b0, 32'h0, 1'b0, 32'h0);
        chk("simfull_ovf", {47'h0, overflow}, 48'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
